// File: rtl/mem_write_buffer_if.sv
// Bus bundle for the posted-write buffer: processor side (P_*), memory
// side (M_*) and buffer status. The buffer sits on the slave modport; the
// agent driving the processor requests and answering memory strobes uses master.
interface mem_write_buffer_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic [ADDR_W-1:0] P_ADDR;
    logic [DATA_W-1:0] P_WDATA;
    logic              P_READ;
    logic              P_WRITE;
    logic [DATA_W-1:0] P_RDATA;
    logic              P_READY;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic              M_READ;
    logic              M_WRITE;
    logic [DATA_W-1:0] M_RDATA;
    logic              M_READY;
    logic [CNT_W-1:0]  FIFO_COUNT;
    logic              EMPTY;

    modport slave (
        input  P_ADDR, P_WDATA, P_READ, P_WRITE, M_RDATA, M_READY,
        output P_RDATA, P_READY, M_ADDR, M_WDATA, M_READ, M_WRITE, FIFO_COUNT, EMPTY
    );

    modport master (
        output P_ADDR, P_WDATA, P_READ, P_WRITE, M_RDATA, M_READY,
        input  P_RDATA, P_READY, M_ADDR, M_WDATA, M_READ, M_WRITE, FIFO_COUNT, EMPTY
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: processor writes land in a small FIFO and are acked
// right away; a drain engine retires them to memory one at a time. Reads
// forward from the youngest matching FIFO entry, otherwise the FIFO is
// drained first and memory is read, so program order is kept.
module mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
) (
    input  logic CLK,
    input  logic RST,
    mem_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic              empty_q, empty_d;
    logic              p_ready_q, p_ready_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  idx;
    logic              wr_req, rd_req, rd_hit, rd_miss, push, pop;

    // Search valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && fifo_addr_q[idx] == bus.P_ADDR) begin
                hit      = 1'b1;
                hit_data = fifo_data_q[idx];
            end
        end
    end

    // Request decode; a request seen while P_READY is high is the one just
    // completed, so it is ignored. Both strobes together is a no-op.
    always_comb begin
        wr_req  = bus.P_WRITE && !bus.P_READ && !p_ready_q;
        rd_req  = bus.P_READ && !bus.P_WRITE && !p_ready_q;
        rd_hit  = rd_req && hit;
        rd_miss = rd_req && !hit;
        pop     = (state_q == MEM_WR) && bus.M_READY;
        // A full FIFO can still take a write on the edge that pops the head.
        push    = wr_req && (state_q != MEM_RD) && (state_q != RESP) &&
                  ((count_q < CNT_W'(DEPTH)) || pop);
    end

    // FIFO bookkeeping, processor response and drain/read FSM next state.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        p_ready_d   = 1'b0;
        p_rdata_d   = p_rdata_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;

        if (push) begin
            fifo_addr_d[wr_ptr_q] = bus.P_ADDR;
            fifo_data_d[wr_ptr_q] = bus.P_WDATA;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            p_ready_d             = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);

        if (rd_hit) begin
            p_ready_d = 1'b1;
            p_rdata_d = hit_data;
        end

        unique case (state_q)
            IDLE: begin
                // Drain whenever something is buffered, unless a forward is
                // being answered this cycle.
                if (count_q != '0 && !rd_hit) begin
                    state_d   = MEM_WR;
                    m_write_d = 1'b1;
                    m_addr_d  = fifo_addr_q[rd_ptr_q];
                    m_wdata_d = fifo_data_q[rd_ptr_q];
                end else if (rd_miss && count_q == '0) begin
                    state_d  = MEM_RD;
                    m_read_d = 1'b1;
                    m_addr_d = bus.P_ADDR;
                end
            end
            MEM_WR: begin
                if (bus.M_READY) begin
                    state_d   = IDLE;
                    m_write_d = 1'b0;
                end
            end
            MEM_RD: begin
                if (bus.M_READY) begin
                    state_d   = RESP;
                    m_read_d  = 1'b0;
                    p_rdata_d = bus.M_RDATA;
                    p_ready_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_addr_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
            empty_q     <= 1'b1;
            p_ready_q   <= 1'b0;
            p_rdata_q   <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            empty_q     <= empty_d;
            p_ready_q   <= p_ready_d;
            p_rdata_q   <= p_rdata_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
        end
    end

    assign bus.P_READY    = p_ready_q;
    assign bus.P_RDATA    = p_rdata_q;
    assign bus.M_ADDR     = m_addr_q;
    assign bus.M_WDATA    = m_wdata_q;
    assign bus.M_READ     = m_read_q;
    assign bus.M_WRITE    = m_write_q;
    assign bus.FIFO_COUNT = count_q;
    assign bus.EMPTY      = empty_q;
endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-write buffer between the DA_VINCI processor bus and the 64M x 32 SRAM model.
- Processor writes are absorbed into a small FIFO and acknowledged at once; a drain engine retires them to memory one at a time.
- Reads are served from the FIFO when the address hits (read-after-write forwarding). Otherwise the FIFO is drained, then the memory is read, so program order is preserved.

Parameters:
DEPTH, 4, write FIFO entries (power of 2, >=2)
ADDR_W, 26, address width (64M words)
DATA_W, 32, data width

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-low reset
P_ADDR  input  ADDR_W  processor address
P_WDATA  input  DATA_W  processor write data
P_READ  input  1  processor read request (level, held until P_READY)
P_WRITE  input  1  processor write request (level, held until P_READY)
P_RDATA  output  DATA_W  read return data
P_READY  output  1  one-cycle completion pulse for current request
M_ADDR  output  ADDR_W  memory address
M_WDATA  output  DATA_W  memory write data
M_READ  output  1  memory read strobe
M_WRITE  output  1  memory write strobe
M_RDATA  input  DATA_W  memory read data, valid when M_READY=1 during M_READ
M_READY  input  1  memory completion for the current strobe
FIFO_COUNT  output  log2(DEPTH)+1  buffered write count
EMPTY  output  1  FIFO_COUNT==0

Behaviour:
- Reset (RST=0 at an edge): all outputs 0, EMPTY=1, FIFO pointers and count cleared, FSM to IDLE. Buffered writes are discarded. A reset during an in-flight memory access drops M_READ/M_WRITE at that edge.
- All outputs are registered.
- Request sampling: a request is ignored in any cycle where P_READY=1. This prevents double acceptance; the processor drops or changes its request after seeing P_READY.
- P_READ=1 and P_WRITE=1 together is illegal: no action, no P_READY.
- Write accept: P_WRITE=1 and count<DEPTH → push {P_ADDR, P_WDATA} at the edge; P_READY=1 in the following cycle. Latency is 1 cycle.
- Write when full: no push and P_READY stays 0 until a pop frees an entry. The push may occur on the same edge as that pop.
- Simultaneous push and pop: count unchanged; pointers both advance modulo DEPTH.
- Read hit: P_READ=1 and any valid entry matches P_ADDR. The youngest matching entry's data goes to P_RDATA, with P_READY=1 the next cycle. There is no memory access and no drain.
- Read miss: the request is held. The FIFO drains fully, then the block issues M_READ. When M_READY=1, M_RDATA is latched into P_RDATA and P_READY=1 the next cycle.
- P_RDATA holds its last value until the next read completes.
- FSM states: IDLE, MEM_WR, MEM_RD, RESP.
  - IDLE→MEM_WR when count>0 and no read hit is pending.
  - IDLE→MEM_RD on a read miss with count==0.
  - MEM_WR: M_WRITE=1 with M_ADDR/M_WDATA = head entry, held stable until M_READY=1. That edge pops the head, drops M_WRITE, and returns to IDLE, so there is one idle cycle between memory strobes.
  - MEM_RD: M_READ=1 with M_ADDR=P_ADDR until M_READY=1, then →RESP.
  - RESP: P_READY=1 for one cycle, then →IDLE.
- While a read miss waits, new writes are not accepted (the processor is stalled on the read anyway).
- Drain proceeds independently of processor write acceptance.

Test Plan:
- Reset: drive RST=0 for 2 edges with P_WRITE=1 → P_READY=0, M_WRITE=0, FIFO_COUNT=0, EMPTY=1. After RST=1, the write of 0x00000001 to 0x01000000 is accepted with P_READY one cycle later.
- Posted write and drain: write 0xDEADBEEF to 0x01000003 with M_READY tied 1 → P_READY 1 cycle after the request. M_WRITE is asserted with M_ADDR=0x1000003 and M_WDATA=0xDEADBEEF, then FIFO_COUNT returns to 0.
- Full stall: hold M_READY=0 and issue 5 writes (addresses 0x1000000–0x1000004) → first 4 acked, FIFO_COUNT=4, 5th P_READY stays 0. Releasing M_READY for one cycle pops the head and the 5th is acked. Memory sees the addresses in order 0x1000000..0x1000004.
- Forwarding: with M_READY=0, write 0x11 then 0x22 to 0x1000008, then read 0x1000008 → P_RDATA=0x22, P_READY 1 cycle later, M_READ never asserted.
- Read miss ordering: buffer writes to 0x1000001 and 0x1000002, then read 0x1000005 (memory returns 0x0000000D) → both M_WRITEs complete before M_READ. P_RDATA=0x0000000D with P_READY the cycle after M_READY.
- Illegal request and mid-operation reset: P_READ=P_WRITE=1 → no P_READY, no FIFO change. Asserting RST=0 while M_WRITE=1 → M_WRITE=0 next edge and FIFO_COUNT=0.
